// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain
//   Read-side consumer for the dual-clock FIFO. Pops show-ahead words from the
//   FIFO read port and re-presents them on a registered valid/ready stream,
//   framed into bursts of burst_len words with m_last on the final word.
//   A two-entry buffer (main + skid) gives full throughput while keeping
//   rinc purely combinational on registered state.
//
// Ports
//   rclk, rrst           read clock, async active-high reset
//   rdata, empty, rinc   FIFO read port (rinc = pop strobe, combinational)
//   enable               level; start/continue draining
//   burst_len            words per burst (0 = 2^BLW), sampled at first pop
//   m_data/m_valid/m_last/m_ready   downstream stream
//   busy                 state != IDLE
//   burst_done           pulse the cycle after a last word is accepted
//   rd_count             saturating count of words popped
module fifo_rd_drain #(
  parameter int DSIZE = 8,
  parameter int BLW   = 8,
  parameter int CW    = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [DSIZE-1:0] rdata,
  input  logic             empty,
  output logic             rinc,
  input  logic             enable,
  input  logic [BLW-1:0]   burst_len,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic             burst_done,
  output logic [CW-1:0]    rd_count
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH, DRAIN} state_t;

  state_t state_q, state_d;

  // Output buffer: main drives m_*, skid absorbs the pop that lands while
  // main is stalled. Skid is only ever valid while main is valid.
  logic             main_vld_q, main_vld_d;
  logic [DSIZE-1:0] main_data_q, main_data_d;
  logic             main_last_q, main_last_d;
  logic             skid_vld_q, skid_vld_d;
  logic [DSIZE-1:0] skid_data_q, skid_data_d;
  logic             skid_last_q, skid_last_d;

  logic [BLW-1:0]   wcnt_q, wcnt_d;
  logic [BLW:0]     blen_q, blen_d;
  logic [CW-1:0]    rd_count_q, rd_count_d;
  logic             burst_done_q, burst_done_d;

  logic [1:0]       occ;
  logic             pop;
  logic             accept;
  logic [BLW:0]     blen_new;
  logic [BLW:0]     blen_cur;
  logic             last_flag;

  assign occ    = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
  assign accept = main_vld_q & m_ready;

  // rrst in the strobe keeps the FIFO untouched while held in reset.
  assign rinc = ((state_q == RUN) || (state_q == FINISH)) && !empty &&
                (occ < 2'd2) && !rrst;
  assign pop  = rinc;

  // Burst length in BLW+1 bits so burst_len=0 can mean a full 2^BLW.
  assign blen_new  = (burst_len == '0) ? {1'b1, {BLW{1'b0}}} : {1'b0, burst_len};
  assign blen_cur  = (wcnt_q == '0) ? blen_new : blen_q;
  assign last_flag = ({1'b0, wcnt_q} == (blen_cur - 1'b1));

  // Burst counter, latched length, statistics.
  always_comb begin
    wcnt_d       = wcnt_q;
    blen_d       = blen_q;
    rd_count_d   = rd_count_q;
    burst_done_d = accept & main_last_q;
    if (pop) begin
      if (wcnt_q == '0) blen_d = blen_new;
      wcnt_d = last_flag ? '0 : wcnt_q + 1'b1;
      if (rd_count_q != '1) rd_count_d = rd_count_q + 1'b1;
    end
  end

  // Buffer movement.
  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    main_last_d = main_last_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    if (accept) begin
      if (skid_vld_q) begin
        main_data_d = skid_data_q;
        main_last_d = skid_last_q;
        if (pop) begin
          skid_data_d = rdata;
          skid_last_d = last_flag;
        end else begin
          skid_vld_d = 1'b0;
        end
      end else if (pop) begin
        main_data_d = rdata;
        main_last_d = last_flag;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (pop) begin
      if (!main_vld_q) begin
        main_vld_d  = 1'b1;
        main_data_d = rdata;
        main_last_d = last_flag;
      end else begin
        // occ<2 on a pop, so skid is free here
        skid_vld_d  = 1'b1;
        skid_data_d = rdata;
        skid_last_d = last_flag;
      end
    end
  end

  // Next state. Leaving RUN uses the post-pop word count: a pop in the same
  // cycle that enable drops may open or close a burst, and only a burst that
  // is still open afterwards needs FINISH.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (enable) state_d = RUN;
      RUN:    if (!enable) state_d = (wcnt_d == '0) ? DRAIN : FINISH;
      FINISH: if (pop && last_flag) state_d = DRAIN;
      DRAIN:  if (occ == 2'd0) state_d = enable ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q      <= IDLE;
      main_vld_q   <= 1'b0;
      main_data_q  <= '0;
      main_last_q  <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      wcnt_q       <= '0;
      blen_q       <= '0;
      rd_count_q   <= '0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_vld_q   <= main_vld_d;
      main_data_q  <= main_data_d;
      main_last_q  <= main_last_d;
      skid_vld_q   <= skid_vld_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      wcnt_q       <= wcnt_d;
      blen_q       <= blen_d;
      rd_count_q   <= rd_count_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign m_data     = main_data_q;
  assign m_valid    = main_vld_q;
  assign m_last     = main_last_q;
  assign busy       = (state_q != IDLE);
  assign burst_done = burst_done_q;
  assign rd_count   = rd_count_q;

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
Read-side consumer for the team's dual-clock FIFO. It lives entirely in the read-clock domain and pops words from the FIFO read port (rdata/empty/rinc). It re-presents the words on a registered valid/ready stream toward downstream logic, framed into bursts of a programmable length with a last-word marker. Full throughput: one word per rclk when the FIFO is non-empty and downstream is ready.

Parameters:
DSIZE, 8, data width; must match the FIFO DSIZE.
BLW, 8, width of burst_len and of the in-burst word counter; burst_len=0 means 2^BLW words.
CW, 16, width of the rd_count statistics counter.

Ports:
rclk  in  1  read-domain clock; all logic is rising-edge.
rrst  in  1  asynchronous, active-high reset.
rdata  in  DSIZE  FIFO read data, show-ahead (valid whenever empty=0).
empty  in  1  FIFO empty flag.
rinc  out  1  FIFO pop strobe; combinational.
enable  in  1  level; start or continue draining.
burst_len  in  BLW  words per burst; sampled at the first pop of each burst.
m_data  out  DSIZE  output word (registered).
m_valid  out  1  m_data/m_last valid.
m_ready  in  1  downstream accepts the word when m_valid&m_ready.
m_last  out  1  marks the final word of a burst.
busy  out  1  state != IDLE.
burst_done  out  1  one-cycle pulse when the last word of a burst is accepted downstream.
rd_count  out  CW  total words popped; saturates at all-ones.

Behaviour:
- Reset (async, rrst=1): state IDLE, m_valid=0, m_data=0, m_last=0, busy=0, burst_done=0, rd_count=0, word counter=0. Both buffer entries are invalid. rinc=0 while rrst=1.
- Output buffer: 2 entries, main (drives m_*) and skid. occ ∈ {0,1,2}. Each entry holds {data, last}.
- Pop rule: rinc = (state==RUN | state==FINISH) & !empty & (occ<2). No other condition pops.
- On an rclk edge with rinc=1: capture {rdata, last_flag} into main if main is empty or being accepted this cycle; otherwise capture into skid.
- Latency: a word popped at edge N appears on m_data after edge N (one cycle of latency).
- Accept (m_valid&m_ready): skid moves to main if skid is valid; else main takes the simultaneous pop; else m_valid drops to 0.
- Sustained flow: with empty=0 and m_ready=1, occ stays at 1 and there is one word per clock.
- Ordering: output order equals pop order. No word is dropped or duplicated under any m_ready pattern.
- Word counter wcnt: increments on each pop. At the first pop of a burst (wcnt=0), latch blen = (burst_len==0 ? 2^BLW : burst_len).
- last_flag = (wcnt == blen-1). On the pop carrying last_flag, wcnt returns to 0.
- rd_count increments on each pop and saturates at all-ones.
- burst_done is asserted for the cycle after an accepted word that has last=1.
State machine:
- IDLE: when enable=1, go to RUN.
- RUN: if enable=0 and wcnt==0, go to DRAIN. If enable=0 and wcnt!=0, go to FINISH; the burst in progress always completes.
- FINISH: keeps popping until the last-flag pop, then goes to DRAIN. If empty, it waits indefinitely.
- DRAIN: no pops. When occ==0: if enable=1 go to RUN, else go to IDLE.
Other rules:
- enable re-asserted during FINISH: the block stays in FINISH until the burst completes, then goes to DRAIN and from there to RUN.
- burst_len changes mid-burst are ignored.
- empty toggling mid-burst stalls the pops only; the burst is not terminated early.
- Reset mid-burst: all state is discarded immediately, including buffered words. Words already popped are lost; this is documented as acceptable.

Test Plan:
- Reset, enable=1, burst_len=4, m_ready=1, FIFO holds 8 words 0x11..0x88 → rinc high 8 consecutive cycles; m_data 0x11..0x88 back-to-back; m_last on 0x44 and 0x88; burst_done pulses twice; rd_count=8.
- Backpressure: m_ready=0 for 5 cycles with FIFO non-empty → exactly 2 pops then rinc=0; releasing m_ready delivers words in order with no loss; occ never exceeds 2.
- enable dropped after the 2nd word of a 4-word burst, FIFO holding 6 words → 2 more pops (m_last on the 4th word), then DRAIN then IDLE; busy=0; 2 words remain in the FIFO.
- burst_len=0, BLW=8 → m_last only on the 256th word; burst_len changed to 3 mid-burst has no effect until the next burst.
- FIFO empties after 2 words of a 4-word burst, refilled 10 cycles later → rinc stays 0 while empty; the burst resumes and m_last lands on the 4th word overall.
- rrst asserted while occ=2 mid-burst → m_valid, rinc, busy and rd_count go to 0 immediately (asynchronously); the next burst starts with wcnt=0.
